// File: rtl/ieeedrv_sd_responder_if.sv
// Sector-transfer bus between track loader, responder and image memory.
// slave = responder view, master = loader/memory view.
interface ieeedrv_sd_responder_if #(
  parameter int SUBDRV = 2,
  parameter int ADDR_W = 21
) ();
  logic [SUBDRV-1:0][31:0] sd_lba;
  logic [SUBDRV-1:0][5:0]  sd_blk_cnt;
  logic [SUBDRV-1:0]       sd_rd;
  logic [SUBDRV-1:0]       sd_wr;
  logic [SUBDRV-1:0]       sd_ack;
  logic [12:0]             sd_buff_addr;
  logic [7:0]              sd_buff_dout;
  logic [SUBDRV-1:0][7:0]  sd_buff_din;
  logic                    sd_buff_wr;
  logic                    img_req;
  logic                    img_we;
  logic                    img_sel;
  logic [ADDR_W-1:0]       img_addr;
  logic [7:0]              img_wdata;
  logic [7:0]              img_rdata;
  logic                    img_ack;

  modport slave (
    input  sd_lba, sd_blk_cnt, sd_rd, sd_wr,
    input  sd_buff_din, img_rdata, img_ack,
    output sd_ack, sd_buff_addr, sd_buff_dout,
    output sd_buff_wr, img_req, img_we,
    output img_sel, img_addr, img_wdata
  );

  modport master (
    output sd_lba, sd_blk_cnt, sd_rd, sd_wr,
    output sd_buff_din, img_rdata, img_ack,
    input  sd_ack, sd_buff_addr, sd_buff_dout,
    input  sd_buff_wr, img_req, img_we,
    input  img_sel, img_addr, img_wdata
  );
endinterface

// File: rtl/ieeedrv_sd_responder.sv
// Serves per-subdrive sector requests, streaming 256-byte blocks
// between a RAM-backed disk image and the drive track buffer.
module ieeedrv_sd_responder #(
  parameter int SUBDRV     = 2,
  parameter int ADDR_W     = 21,
  parameter int IMG_BLOCKS = 4166
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [SUBDRV-1:0] mounted,
  ieeedrv_sd_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    RD_MEM,
    RD_BUF,
    WR_BUF,
    WR_MEM,
    DONE
  } state_t;

  state_t            r_state;
  logic              r_ptr;
  logic              r_sel;
  logic              r_wr;
  logic [31:0]       r_lba;
  logic [4:0]        r_cnt;
  logic [12:0]       r_n;
  logic              r_wph;
  logic [7:0]        r_data;
  logic [1:0]        r_ack;
  logic [12:0]       r_buff_addr;
  logic [7:0]        r_buff_dout;
  logic              r_buff_wr;
  logic              r_img_req;
  logic              r_img_we;
  logic [ADDR_W-1:0] r_img_addr;
  logic [7:0]        r_img_wdata;

  // Requests widened to two lanes; absent lanes read as idle.
  logic [1:0]       w_req;
  logic [1:0]       w_wr;
  logic [1:0]       w_mnt;
  logic [1:0][31:0] w_lba;
  logic [1:0][5:0]  w_cnt;
  logic [1:0][7:0]  w_din;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    if (g < SUBDRV) begin : g_on
      assign w_req[g] = bus.sd_rd[g] | bus.sd_wr[g];
      assign w_wr[g]  = bus.sd_wr[g];
      assign w_mnt[g] = mounted[g];
      assign w_lba[g] = bus.sd_lba[g];
      assign w_cnt[g] = bus.sd_blk_cnt[g];
      assign w_din[g] = bus.sd_buff_din[g];
    end else begin : g_off
      assign w_req[g] = 1'b0;
      assign w_wr[g]  = 1'b0;
      assign w_mnt[g] = 1'b0;
      assign w_lba[g] = '0;
      assign w_cnt[g] = '0;
      assign w_din[g] = '0;
    end
  end

  logic              w_any;
  logic              w_pick;
  logic [4:0]        w_clamp;
  logic              w_last;
  logic [12:0]       w_n_inc;
  logic [32:0]       w_blk;
  logic              w_inrng;
  logic [ADDR_W-1:0] w_addr;

  assign w_any = |w_req;

  always_comb begin
    w_pick = r_ptr;
    if (!w_req[r_ptr]) w_pick = ~r_ptr;
  end

  assign w_clamp = w_cnt[w_pick][5] ? 5'd31
                                    : w_cnt[w_pick][4:0];

  assign w_last  = (r_n == {r_cnt, 8'hFF});
  assign w_n_inc = r_n + 13'd1;

  assign w_blk = {1'b0, r_lba} + 33'(r_n[12:8]);

  assign w_inrng = w_mnt[r_sel]
                 & (w_blk < 33'(IMG_BLOCKS));

  assign w_addr = ADDR_W'({r_lba, 8'h00}
                        + 40'(r_n));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_sel       <= 1'b0;
      r_wr        <= 1'b0;
      r_lba       <= '0;
      r_cnt       <= '0;
      r_n         <= '0;
      r_wph       <= 1'b0;
      r_data      <= '0;
      r_ack       <= '0;
      r_buff_addr <= '0;
      r_buff_dout <= '0;
      r_buff_wr   <= 1'b0;
      r_img_req   <= 1'b0;
      r_img_we    <= 1'b0;
      r_img_addr  <= '0;
      r_img_wdata <= '0;
    end else begin
      r_buff_wr <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel   <= w_pick;
            r_lba   <= w_lba[w_pick];
            r_wr    <= w_wr[w_pick];
            r_cnt   <= w_clamp;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          r_ack       <= 2'b01 << r_sel;
          r_n         <= '0;
          r_wph       <= 1'b0;
          r_buff_addr <= '0;
          r_state     <= r_wr ? WR_BUF : RD_MEM;
        end
        RD_MEM: begin
          if (r_img_req) begin
            if (bus.img_ack) begin
              r_img_req <= 1'b0;
              r_data    <= bus.img_rdata;
              r_state   <= RD_BUF;
            end
          end else if (w_inrng) begin
            r_img_req  <= 1'b1;
            r_img_we   <= 1'b0;
            r_img_addr <= w_addr;
          end else begin
            r_data  <= 8'h00;
            r_state <= RD_BUF;
          end
        end
        RD_BUF: begin
          r_buff_addr <= r_n;
          r_buff_dout <= r_data;
          r_buff_wr   <= 1'b1;
          if (w_last) begin
            r_state <= DONE;
          end else begin
            r_n     <= w_n_inc;
            r_state <= RD_MEM;
          end
        end
        WR_BUF: begin
          // One wait cycle covers the buffer read latency.
          if (!r_wph) begin
            r_wph <= 1'b1;
          end else begin
            r_wph       <= 1'b0;
            r_img_wdata <= w_din[r_sel];
            r_state     <= WR_MEM;
          end
        end
        WR_MEM: begin
          if (r_img_req) begin
            if (bus.img_ack) begin
              r_img_req <= 1'b0;
              r_img_we  <= 1'b0;
              if (w_last) begin
                r_state <= DONE;
              end else begin
                r_n         <= w_n_inc;
                r_buff_addr <= w_n_inc;
                r_state     <= WR_BUF;
              end
            end
          end else if (w_inrng) begin
            r_img_req  <= 1'b1;
            r_img_we   <= 1'b1;
            r_img_addr <= w_addr;
          end else if (w_last) begin
            r_state <= DONE;
          end else begin
            r_n         <= w_n_inc;
            r_buff_addr <= w_n_inc;
            r_state     <= WR_BUF;
          end
        end
        DONE: begin
          r_ack   <= '0;
          r_ptr   <= (SUBDRV == 2) ? ~r_sel : 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sd_ack       = r_ack[SUBDRV-1:0];
  assign bus.sd_buff_addr = r_buff_addr;
  assign bus.sd_buff_dout = r_buff_dout;
  assign bus.sd_buff_wr   = r_buff_wr;
  assign bus.img_req      = r_img_req;
  assign bus.img_we       = r_img_we;
  assign bus.img_sel      = r_sel;
  assign bus.img_addr     = r_img_addr;
  assign bus.img_wdata    = r_img_wdata;

endmodule
